// File: rtl/fifo_burst_reader.sv
// Read-domain consumer for the async FIFO: issues bursts of FIFO pops and buffers the
// returned words for a valid/ready stream, counting every word accepted downstream.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 16,
    parameter int TIMEOUT    = 64,
    parameter int OBUF_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  fifo_rempty,
    input  logic                  fifo_half_rempty,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int OW = PW + 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    localparam logic [WW-1:0] WAIT_MAX   = WW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [OW-1:0] OBUF_FULL  = OW'(OBUF_DEPTH);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                state_q, state_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic                  inflight_q;
    logic [OW-1:0]         occ_q, occ_d;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
    logic [CNT_WIDTH-1:0]  rd_count_q;

    logic rd_en;
    logic room;
    logic pop;

    // A word already in flight counts against the buffer so its capture never overflows.
    assign room = (occ_q + OW'(inflight_q)) < OBUF_FULL;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        burst_d = burst_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_rempty) begin
                    wait_d = '0;
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + 1'b1;
                end
                if (fifo_half_rempty || (!fifo_rempty && (wait_q == WAIT_MAX))) begin
                    state_d = BURST;
                    wait_d  = '0;
                    burst_d = '0;
                end
            end
            BURST: begin
                wait_d = '0;
                if (fifo_rempty) begin
                    state_d = IDLE;
                end else if (room) begin
                    rd_en   = 1'b1;
                    burst_d = burst_q + 1'b1;
                    if (burst_q == BURST_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_valid = (occ_q != '0);
    assign pop     = m_valid & m_ready;

    always_comb begin
        occ_d = occ_q;
        if (inflight_q && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!inflight_q && pop) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            burst_q    <= '0;
            inflight_q <= 1'b0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_count_q <= '0;
            for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            burst_q    <= burst_d;
            inflight_q <= rd_en;
            occ_q      <= occ_d;
            if (inflight_q) begin
                mem_q[wr_ptr_q] <= fifo_rdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                rd_count_q <= rd_count_q + 1'b1;
            end
        end
    end

    assign fifo_read_enable = rd_en;
    assign m_data           = mem_q[rd_ptr_q];
    assign busy             = (state_q == BURST) | inflight_q | m_valid;
    assign rd_count         = rd_count_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a behavioural FIFO feeds the DUT and a monitor
// logs read strobes and delivered words for comparison against hand-computed values.
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          rclk   = 1'b0;
    logic          rrst_n = 1'b1;
    logic          m_ready = 1'b0;
    logic          half_force = 1'b0;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rempty, fifo_half_rempty, fifo_read_enable;
    logic          m_valid, busy;
    logic [DW-1:0] m_data;
    logic [CW-1:0] rd_count;

    logic [7:0] fmem [512];
    int fwr = 0;
    int frd = 0;
    int cyc = 0;

    int rd_log [1024];
    int nre = 0;
    int bad_rd = 0;
    logic [7:0] got [1024];
    int gcnt = 0;
    int mv_rise = -1;
    logic mv_prev = 1'b0;

    logic [7:0] exp_words [1024];
    int ne = 0;
    int gidx = 0;

    int n_run = 0;
    int n_fail = 0;

    assign fifo_rempty      = (fwr == frd);
    assign fifo_half_rempty = half_force | ((fwr - frd) >= 256);

    always #5 rclk = ~rclk;

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (16),
        .TIMEOUT    (64),
        .OBUF_DEPTH (4),
        .CNT_WIDTH  (CW)
    ) dut (
        .rclk             (rclk),
        .rrst_n           (rrst_n),
        .fifo_rempty      (fifo_rempty),
        .fifo_half_rempty (fifo_half_rempty),
        .fifo_read_enable (fifo_read_enable),
        .fifo_rdata       (fifo_rdata),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .busy             (busy),
        .rd_count         (rd_count)
    );

    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (fifo_read_enable && (fwr != frd)) begin
            fifo_rdata <= fmem[frd % 512];
            frd        <= frd + 1;
        end
    end

    always @(negedge rclk) begin
        if (fifo_read_enable) begin
            if (nre < 1024) rd_log[nre] = cyc;
            nre = nre + 1;
            if (fifo_rempty) bad_rd = bad_rd + 1;
        end
        if (m_valid && m_ready) begin
            if (gcnt < 1024) got[gcnt] = m_data;
            gcnt = gcnt + 1;
        end
        if (m_valid && !mv_prev) mv_rise = cyc;
        mv_prev = m_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_run = n_run + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic push(input int n, input logic [7:0] base, input bit track);
        for (int i = 0; i < n; i++) begin
            fmem[(fwr + i) % 512] = base + 8'(i);
            if (track) begin
                exp_words[ne] = base + 8'(i);
                ne = ne + 1;
            end
        end
        fwr = fwr + n;
    endtask

    task automatic kick();
        half_force = 1'b1;
        step();
        half_force = 1'b0;
    endtask

    task automatic wait_read(input int b, input int budget);
        for (int i = 0; i < budget && nre == b; i++) step();
        check_eq("rd_start", 32'(nre > b), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy && (fwr == frd)) break;
            step();
        end
        check_eq({tag, "_idle"}, {30'd0, busy, (fwr != frd)}, 32'd0);
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_nwords"}, 32'(gcnt), 32'(ne));
        for (int i = gidx; i < gcnt && i < ne; i++) begin
            check_eq({tag, "_word"}, 32'(got[i]), 32'(exp_words[i]));
        end
        gidx = gcnt;
    endtask

    initial begin
        int b, t0, k, g0;

        #1 rrst_n = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        check_eq("rst_rd_en",  32'(fifo_read_enable), 32'd0);
        check_eq("rst_valid",  32'(m_valid), 32'd0);
        check_eq("rst_data",   32'(m_data), 32'd0);
        check_eq("rst_busy",   32'(busy), 32'd0);
        check_eq("rst_count",  32'(rd_count), 32'd0);
        rrst_n = 1'b1;
        step();

        // burst start, throughput and minimum inter-burst gap
        m_ready = 1'b1;
        b = nre;
        push(300, 8'h00, 1'b1);
        wait_read(b, 50);
        t0 = rd_log[b];
        wait_cyc(t0 + 3);
        check_eq("t1_latency", 32'(mv_rise - t0), 32'd2);
        wait_idle("t1", 3000);
        check_eq("t1_b2b", 32'(rd_log[b + 15] - t0), 32'd15);
        check_eq("t1_gap", 32'(rd_log[b + 16] - t0), 32'd17);
        check_eq("t1_nreads", 32'(nre - b), 32'd300);
        check_stream("t1");
        check_eq("t1_count", 32'(rd_count), 32'd12);

        // timeout path with three words below the half mark
        b = nre;
        k = cyc;
        push(3, 8'hA0, 1'b1);
        wait_cyc(k + 63);
        check_eq("t2_quiet", 32'(nre - b), 32'd0);
        wait_cyc(k + 68);
        check_eq("t2_first", 32'(rd_log[b] - k), 32'd64);
        check_eq("t2_nreads", 32'(nre - b), 32'd3);
        check_eq("t2_busy_hi", 32'(busy), 32'd1);
        wait_cyc(k + 69);
        check_eq("t2_busy_lo", 32'(busy), 32'd0);
        check_stream("t2");
        check_eq("t2_count", 32'(rd_count), 32'd15);

        // backpressure stalls reads at four outstanding words
        m_ready = 1'b0;
        b = nre;
        push(10, 8'h50, 1'b1);
        kick();
        repeat (10) step();
        check_eq("t3_stall_reads", 32'(nre - b), 32'd4);
        check_eq("t3_valid", 32'(m_valid), 32'd1);
        check_eq("t3_hold0", 32'(m_data), 32'h50);
        check_eq("t3_busy", 32'(busy), 32'd1);
        repeat (3) step();
        check_eq("t3_hold1", 32'(m_data), 32'h50);
        check_eq("t3_still", 32'(nre - b), 32'd4);
        m_ready = 1'b1;
        wait_idle("t3", 200);
        check_eq("t3_nreads", 32'(nre - b), 32'd10);
        check_stream("t3");
        check_eq("t3_count", 32'(rd_count), 32'd9);

        // FIFO runs dry after five reads
        b = nre;
        push(5, 8'h30, 1'b1);
        kick();
        wait_idle("t4", 100);
        check_eq("t4_nreads", 32'(nre - b), 32'd5);
        check_stream("t4");
        check_eq("t4_count", 32'(rd_count), 32'd14);

        // asynchronous reset with three buffered words and one in flight
        m_ready = 1'b0;
        b = nre;
        push(10, 8'h70, 1'b0);
        kick();
        wait_read(b, 20);
        t0 = rd_log[b];
        wait_cyc(t0 + 4);
        check_eq("t5_pre_valid", 32'(m_valid), 32'd1);
        rrst_n = 1'b0;
        #1;
        check_eq("t5_rd_en",  32'(fifo_read_enable), 32'd0);
        check_eq("t5_valid",  32'(m_valid), 32'd0);
        check_eq("t5_data",   32'(m_data), 32'd0);
        check_eq("t5_busy",   32'(busy), 32'd0);
        check_eq("t5_count",  32'(rd_count), 32'd0);
        fwr = frd;
        step();
        step();
        rrst_n = 1'b1;
        m_ready = 1'b1;
        g0 = gcnt;
        repeat (10) step();
        check_eq("t5_no_stale", 32'(gcnt - g0), 32'd0);
        check_eq("t5_post_busy", 32'(busy), 32'd0);

        // counter wrap: 18 words into a 4-bit count
        b = nre;
        push(18, 8'hC0, 1'b1);
        kick();
        wait_idle("t6", 300);
        check_eq("t6_nreads", 32'(nre - b), 32'd18);
        check_stream("t6");
        check_eq("t6_count", 32'(rd_count), 32'd2);

        check_eq("empty_reads", 32'(bad_rd), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
